// File: rtl/univ_shift_reg_if.sv
// Control and data bundle for univ_shift_reg: op/start/amount/load/serial inputs,
// register contents and sequencing status outputs.
interface univ_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
);
    logic [2:0]       op;
    logic             start;
    logic [AMT_W-1:0] amount;
    logic [WIDTH-1:0] D_in;
    logic             ser_in;
    logic [WIDTH-1:0] D_out;
    logic             ser_msb;
    logic             ser_lsb;
    logic             busy;
    logic             done;

    modport master (
        output op, start, amount, D_in, ser_in,
        input  D_out, ser_msb, ser_lsb, busy, done
    );

    modport slave (
        input  op, start, amount, D_in, ser_in,
        output D_out, ser_msb, ser_lsb, busy, done
    );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: single-step ops every edge in IDLE, or a sequenced
// multi-step shift/rotate that runs one step per cycle with busy/done status.
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input logic            clk,
    input logic            reset,
    univ_shift_reg_if.slave bus
);
    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] data, data_nx;
    logic [AMT_W-1:0] count, count_nx;
    logic [2:0]       lat_op, lat_op_nx;
    logic             done_q, done_nx;

    function automatic logic is_shift(input logic [2:0] o);
        return (o == OP_SHL) || (o == OP_SHR) || (o == OP_ROL) ||
               (o == OP_ROR) || (o == OP_ASR);
    endfunction

    function automatic logic [WIDTH-1:0] step(input logic [2:0]       o,
                                              input logic [WIDTH-1:0] d,
                                              input logic [WIDTH-1:0] ld,
                                              input logic             s);
        logic signed [WIDTH-1:0] sd;
        sd = d;
        case (o)
            OP_LOAD: step = ld;
            OP_SHL:  step = {d[WIDTH-2:0], s};
            OP_SHR:  step = {s, d[WIDTH-1:1]};
            OP_ROL:  step = {d[WIDTH-2:0], d[WIDTH-1]};
            OP_ROR:  step = {d[0], d[WIDTH-1:1]};
            OP_ASR:  step = sd >>> 1;
            default: step = d;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            data   <= '0;
            count  <= '0;
            lat_op <= OP_HOLD;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            data   <= data_nx;
            count  <= count_nx;
            lat_op <= lat_op_nx;
            done_q <= done_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        data_nx   = data;
        count_nx  = count;
        lat_op_nx = lat_op;
        done_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && is_shift(bus.op) && (bus.amount != '0)) begin
                    lat_op_nx = bus.op;
                    count_nx  = bus.amount;
                    state_nx  = BUSY;
                end else begin
                    // A zero-length sequenced shift completes without touching data.
                    if (!(bus.start && is_shift(bus.op)))
                        data_nx = step(bus.op, data, bus.D_in, bus.ser_in);
                    done_nx = bus.start;
                end
            end
            BUSY: begin
                data_nx = step(lat_op, data, bus.D_in, bus.ser_in);
                if (count == AMT_W'(1)) begin
                    count_nx = '0;
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end else begin
                    count_nx = count - AMT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.D_out   = data;
    assign bus.ser_msb = data[WIDTH-1];
    assign bus.ser_lsb = data[0];
    assign bus.busy    = (state == BUSY);
    assign bus.done    = done_q;
endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: arithmetic reference model checked every cycle on the
// 8-bit instance, plus directed literal expectations on 8-bit and 4-bit instances.
module tb_univ_shift_reg;
    logic clk;
    logic reset;
    logic clk_en;
    logic chk_on;
    int   n_cmp;
    int   n_bad;

    univ_shift_reg_if #(.WIDTH(8)) i8 ();
    univ_shift_reg_if #(.WIDTH(4)) i4 ();

    univ_shift_reg #(.WIDTH(8)) u8 (.clk(clk), .reset(reset), .bus(i8));
    univ_shift_reg #(.WIDTH(4)) u4 (.clk(clk), .reset(reset), .bus(i4));

    initial clk = 1'b0;
    always #5 clk = clk_en ? ~clk : clk;

    // Reference model state: value, steps still owed, latched op, done flag.
    logic [7:0] m_d;
    int         m_rem;
    logic [2:0] m_op;
    logic       m_done;

    function automatic logic is_sh(input logic [2:0] o);
        return (o >= 3'd2) && (o <= 3'd6);
    endfunction

    function automatic logic [7:0] m_step(input logic [2:0] o, input logic [7:0] d,
                                          input logic [7:0] ld, input logic s);
        int v;
        int si;
        v  = int'(d);
        si = s ? 1 : 0;
        case (o)
            3'd1:    return ld;
            3'd2:    return 8'((v * 2 + si) % 256);
            3'd3:    return 8'(v / 2 + si * 128);
            3'd4:    return 8'((v * 2) % 256 + v / 128);
            3'd5:    return 8'(v / 2 + (v % 2) * 128);
            3'd6:    return 8'(v / 2 + (v / 128) * 128);
            default: return d;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_d    <= 8'h00;
            m_rem  <= 0;
            m_op   <= 3'd0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_rem > 0) begin
                m_d   <= m_step(m_op, m_d, 8'h00, i8.ser_in);
                m_rem <= m_rem - 1;
                if (m_rem == 1) m_done <= 1'b1;
            end else if (i8.start && is_sh(i8.op) && (i8.amount != 4'd0)) begin
                m_op  <= i8.op;
                m_rem <= int'(i8.amount);
            end else begin
                if (!(i8.start && is_sh(i8.op)))
                    m_d <= m_step(i8.op, m_d, i8.D_in, i8.ser_in);
                m_done <= i8.start;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on)
            chk("model", 32'({i8.D_out, i8.ser_msb, i8.ser_lsb, i8.busy, i8.done}),
                32'({m_d, m_d[7], m_d[0], (m_rem != 0), m_done}));
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drv(input logic [2:0] o, input logic s, input logic [3:0] a,
                       input logic [7:0] d, input logic si);
        i8.op     = o;
        i8.start  = s;
        i8.amount = a;
        i8.D_in   = d;
        i8.ser_in = si;
    endtask

    // Packs busy, done and D_out of the 8-bit instance for literal checks.
    function automatic logic [31:0] st8();
        return 32'({i8.busy, i8.done, i8.D_out});
    endfunction

    function automatic logic [31:0] ex8(input logic b, input logic dn, input logic [7:0] d);
        return 32'({b, dn, d});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        chk_on = 1'b0;
        clk_en = 1'b0;
        reset  = 1'b1;
        drv(3'd1, 1'b1, 4'd5, 8'hFF, 1'b1);
        i4.op = 3'd2; i4.start = 1'b1; i4.amount = 3'd3; i4.D_in = 4'hF; i4.ser_in = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("reset8", st8(), ex8(1'b0, 1'b0, 8'h00));
        chk("reset4", 32'({i4.busy, i4.done, i4.D_out}), 32'({1'b0, 1'b0, 4'h0}));
        drv(3'd0, 1'b0, 4'd0, 8'h00, 1'b0);
        i4.op = 3'd0; i4.start = 1'b0; i4.amount = 3'd0; i4.D_in = 4'h0; i4.ser_in = 1'b0;
        clk_en = 1'b1;
        @(negedge clk);
        reset  = 1'b1;
        chk_on = 1'b1;

        i4.op = 3'd1; i4.D_in = 4'b1110; tick(); chk("w4_load", 32'(i4.D_out), 32'(4'hE));
        i4.op = 3'd2; tick(); chk("w4_shl1", 32'(i4.D_out), 32'(4'hC));
        tick(); chk("w4_shl2", 32'(i4.D_out), 32'(4'h8));
        i4.op = 3'd3; tick(); chk("w4_shr1", 32'(i4.D_out), 32'(4'h4));
        tick(); chk("w4_shr2", 32'(i4.D_out), 32'(4'h2));
        i4.op = 3'd0; tick(); chk("w4_hold", 32'(i4.D_out), 32'(4'h2));

        drv(3'd1, 0, 0, 8'hB4, 0); tick(); chk("load_b4", st8(), ex8(0, 0, 8'hB4));
        drv(3'd2, 0, 0, 8'h00, 1); tick(); chk("shl_fill1", st8(), ex8(0, 0, 8'h69));
        drv(3'd3, 0, 0, 8'h00, 0); tick(); chk("shr_fill0", st8(), ex8(0, 0, 8'h34));
        drv(3'd5, 0, 0, 8'h00, 0); tick(); chk("ror1", st8(), ex8(0, 0, 8'h1A));
        drv(3'd6, 0, 0, 8'h00, 0); tick(); chk("asr1", st8(), ex8(0, 0, 8'h0D));
        drv(3'd4, 0, 0, 8'h00, 0); tick(); chk("rol1", st8(), ex8(0, 0, 8'h1A));
        drv(3'd7, 0, 0, 8'hFF, 1); tick(); chk("reserved", st8(), ex8(0, 0, 8'h1A));

        drv(3'd1, 0, 0, 8'h81, 0); tick();
        drv(3'd4, 1, 3, 8'h00, 0); tick(); chk("rol3_start", st8(), ex8(1, 0, 8'h81));
        drv(3'd1, 0, 0, 8'hFF, 0); tick(); chk("rol3_s1", st8(), ex8(1, 0, 8'h03));
        tick(); chk("rol3_s2", st8(), ex8(1, 0, 8'h06));
        drv(3'd0, 0, 0, 8'h00, 0); tick(); chk("rol3_done", st8(), ex8(0, 1, 8'h0C));
        tick(); chk("rol3_after", st8(), ex8(0, 0, 8'h0C));

        drv(3'd1, 0, 0, 8'h90, 0); tick();
        drv(3'd6, 1, 2, 8'h00, 0); tick(); chk("asr2_start", st8(), ex8(1, 0, 8'h90));
        drv(3'd4, 1, 5, 8'h00, 0); tick(); chk("asr2_s1", st8(), ex8(1, 0, 8'hC8));
        drv(3'd0, 0, 0, 8'h00, 0); tick(); chk("asr2_done", st8(), ex8(0, 1, 8'hE4));
        drv(3'd2, 1, 0, 8'h00, 1); tick(); chk("amt0_done", st8(), ex8(0, 1, 8'hE4));
        drv(3'd0, 0, 0, 8'h00, 0); tick(); chk("amt0_after", st8(), ex8(0, 0, 8'hE4));
        drv(3'd1, 1, 3, 8'h5A, 0); tick(); chk("load_start", st8(), ex8(0, 1, 8'h5A));

        drv(3'd5, 1, 1, 8'h00, 0); tick(); chk("held_start", st8(), ex8(1, 0, 8'h5A));
        tick(); chk("held_done1", st8(), ex8(0, 1, 8'h2D));
        tick(); chk("held_restart", st8(), ex8(1, 0, 8'h2D));
        drv(3'd0, 0, 0, 8'h00, 0); tick(); chk("held_done2", st8(), ex8(0, 1, 8'h96));

        drv(3'd1, 0, 0, 8'h81, 0); tick();
        drv(3'd4, 1, 9, 8'h00, 0); tick();
        drv(3'd0, 0, 0, 8'h00, 0);
        for (int k = 0; k < 8; k++) tick();
        chk("rol9_busy", 32'(i8.busy), 32'(1'b1));
        tick(); chk("rol9_wrap", st8(), ex8(0, 1, 8'h03));

        drv(3'd3, 1, 12, 8'h00, 1); tick();
        drv(3'd0, 0, 0, 8'h00, 1);
        for (int k = 0; k < 11; k++) tick();
        tick(); chk("shr12_sat", st8(), ex8(0, 1, 8'hFF));

        drv(3'd1, 0, 0, 8'h80, 0); tick();
        drv(3'd6, 1, 10, 8'h00, 0); tick();
        drv(3'd0, 0, 0, 8'h00, 0);
        for (int k = 0; k < 9; k++) tick();
        tick(); chk("asr10_sat", st8(), ex8(0, 1, 8'hFF));

        drv(3'd1, 0, 0, 8'hA5, 0); tick();
        drv(3'd5, 1, 5, 8'h00, 0); tick(); chk("ror5_start", st8(), ex8(1, 0, 8'hA5));
        drv(3'd0, 0, 0, 8'h00, 0); tick(); chk("ror5_s1", st8(), ex8(1, 0, 8'hD2));
        tick(); chk("ror5_s2", st8(), ex8(1, 0, 8'h69));
        #2 reset = 1'b0;
        #1 chk("abort_async", st8(), ex8(0, 0, 8'h00));
        @(negedge clk); chk("abort_held", st8(), ex8(0, 0, 8'h00));
        reset = 1'b1;
        tick(); chk("abort_nodone", st8(), ex8(0, 0, 8'h00));
        tick(); chk("abort_hold", st8(), ex8(0, 0, 8'h00));

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
